fp32_align_add: RTL and testbench
=================================

Name: fp32_align_add

Overview:
- Pipelined single-precision exponent-align and mantissa add/subtract stage.
- Sits directly upstream of the leading-zero normalizer. It delivers the 8-bit exponent and the 24-bit unnormalized magnitude (hidden bit at [23]) that the normalizer consumes.
- Three-stage pipeline with valid/ready handshake on both sides.
- Rounding and sticky handling are out of scope: shifted-out bits are truncated.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width; datapath magnitude is MAN_W+1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept operands this cycle.
- a  input  32  IEEE-754 operand A.
- b  input  32  IEEE-754 operand B.
- op  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sign  output  1  result sign.
- out_exp  output  8  result exponent (to normalizer E).
- out_man  output  24  result magnitude, hidden bit at [23] (to normalizer In).
- out_zero  output  1  exact zero result.
- out_special  output  1  an input had exponent 0xFF.
- out_ovf  output  1  carry pushed exponent to 0xFF.

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits clear.
  - out_valid=0, all other outputs 0.
  - in_ready=1 after reset deasserts.
  - Reset mid-operation discards all in-flight operations.
- Handshake:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - Global stall = out_valid && !out_ready. During a stall all stage registers hold.
  - in_ready = !stall, combinational from out_ready.
  - No bubbles collapse during stall. Order is preserved. No operation is lost or duplicated.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 op/cycle.
- Stage 1 (unpack/compare):
  - Effective sign of B = b[31]^op.
  - Exponent 0 is treated as zero: mantissa 0, denormals flushed.
  - Otherwise mantissa = {1, frac}.
  - Compare {exp, frac} magnitudes. If B > A, swap so "large" holds the greater magnitude; ties keep A as large.
  - d = exp_large − exp_small (8-bit, never negative).
  - eff_sub = sign_large ^ sign_small.
  - special = (a exp==0xFF) || (b exp==0xFF).
- Stage 2 (align):
  - man_small >>= d.
  - If d >= 24, man_small = 0.
  - Shifted-out bits are discarded.
- Stage 3 (add/sub):
  - sum25 = eff_sub ? man_large − man_small : man_large + man_small.
  - If sum25[24]=1 (add carry): out_man = sum25[24:1], out_exp = exp_large+1.
  - Else: out_man = sum25[23:0], out_exp = exp_large.
  - out_sign = sign_large.
  - If sum25==0: out_zero=1, out_sign=0, out_man=0, out_exp=exp_large.
  - out_ovf=1 when carry and exp_large==0xFE. In that case out_exp=0xFF and out_man = sum25[24:1] unchanged.
  - If special: out_special=1, out_exp=0xFF, out_man=0x800000, out_sign=sign_large, out_zero=0, out_ovf=0. Arithmetic result is ignored.
- Result flags are registered alongside data and are only meaningful when out_valid=1.
- Subtraction never produces a borrow beyond bit 23, because the swap guarantees large >= small.

Test Plan:
- 0x3F800000 + 0x3F800000, op=0, out_ready=1 -> 3 cycles later out_valid=1, out_exp=0x80, out_man=0x800000, out_sign=0.
- 0x3F800000 − 0x3F800000 (op=1) -> out_zero=1, out_man=0, out_sign=0, out_exp=0x7F.
- 0x3FC00000 − 0x3F800000 -> out_man=0x400000, out_exp=0x7F, out_sign=0. Result is unnormalized for the downstream normalizer. Also 0x3F800000 − 0x3FC00000 -> same man/exp with out_sign=1 (swap path).
- 0x4B800000 + 0x3F800000 (d=24) -> out_man=0x800000, out_exp=0x97 (small operand dropped). 0x7F7FFFFF + 0x7F7FFFFF -> out_ovf=1, out_exp=0xFF, out_man=0xFFFFFF.
- 0x7F800000 + 0x3F800000 -> out_special=1, out_exp=0xFF, out_man=0x800000, out_sign=0.
- Backpressure and reset:
  - Stream 5 back-to-back ops, drop out_ready for 3 cycles after the first result -> in_ready=0 during stall, outputs held stable, all 5 results emerge in order with none lost.
  - Assert rst with 2 ops in flight -> out_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/fp32_align_add.sv
`default_nettype none
// ============================================================================
// Module   : fp32_align_add
// Brief    : Three-stage FP32 exponent-align and magnitude add/subtract,
//            producing an unnormalized result for the leading-zero normalizer.
// Revision : 1.0
// ============================================================================
module fp32_align_add #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [EXP_W-1:0]     out_exp,
    output logic [MAN_W:0]       out_man,
    output logic                 out_zero,
    output logic                 out_special,
    output logic                 out_ovf
);

    localparam int               SIG_W      = MAN_W + 1;
    localparam int               MAG_W      = EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] C_EXP_MAX  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] C_EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [SIG_W-1:0] C_SIG_NAN  = {1'b1, {MAN_W{1'b0}}};

    logic               w_stall;

    // Stage 1: unpack / compare / swap
    logic [EXP_W-1:0]   w_exp_a;
    logic [EXP_W-1:0]   w_exp_b;
    logic [EXP_W-1:0]   w_exp_s;
    logic [SIG_W-1:0]   w_sig_a;
    logic [SIG_W-1:0]   w_sig_b;
    logic               w_sgn_a;
    logic               w_sgn_b;
    logic               w_b_larger;

    logic               s1_valid_d,   s1_valid_q;
    logic               s1_sign_l_d,  s1_sign_l_q;
    logic [EXP_W-1:0]   s1_exp_l_d,   s1_exp_l_q;
    logic [SIG_W-1:0]   s1_man_l_d,   s1_man_l_q;
    logic [SIG_W-1:0]   s1_man_s_d,   s1_man_s_q;
    logic [EXP_W-1:0]   s1_shift_d,   s1_shift_q;
    logic               s1_eff_sub_d, s1_eff_sub_q;
    logic               s1_special_d, s1_special_q;

    // Stage 2: align
    logic               s2_valid_d,   s2_valid_q;
    logic               s2_sign_l_d,  s2_sign_l_q;
    logic [EXP_W-1:0]   s2_exp_l_d,   s2_exp_l_q;
    logic [SIG_W-1:0]   s2_man_l_d,   s2_man_l_q;
    logic [SIG_W-1:0]   s2_man_s_d,   s2_man_s_q;
    logic               s2_eff_sub_d, s2_eff_sub_q;
    logic               s2_special_d, s2_special_q;

    // Stage 3: add / subtract, result registers
    logic [SIG_W:0]     w_sum;
    logic               w_carry;
    logic               out_valid_d,   out_valid_q;
    logic               out_sign_d,    out_sign_q;
    logic [EXP_W-1:0]   out_exp_d,     out_exp_q;
    logic [SIG_W-1:0]   out_man_d,     out_man_q;
    logic               out_zero_d,    out_zero_q;
    logic               out_special_d, out_special_q;
    logic               out_ovf_d,     out_ovf_q;

    // A held result freezes the whole pipe; bubbles are not squeezed out.
    assign w_stall  = out_valid_q && !out_ready;
    assign in_ready = !w_stall;

    assign w_exp_a    = a[MAG_W-1:MAN_W];
    assign w_exp_b    = b[MAG_W-1:MAN_W];
    assign w_sgn_a    = a[MAG_W];
    assign w_sgn_b    = b[MAG_W] ^ op;
    assign w_sig_a    = (w_exp_a == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    assign w_sig_b    = (w_exp_b == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    assign w_b_larger = b[MAG_W-1:0] > a[MAG_W-1:0];
    assign w_exp_s    = w_b_larger ? w_exp_a : w_exp_b;

    always_comb begin
        s1_valid_d   = in_valid;
        s1_sign_l_d  = w_b_larger ? w_sgn_b : w_sgn_a;
        s1_exp_l_d   = w_b_larger ? w_exp_b : w_exp_a;
        s1_man_l_d   = w_b_larger ? w_sig_b : w_sig_a;
        s1_man_s_d   = w_b_larger ? w_sig_a : w_sig_b;
        s1_shift_d   = s1_exp_l_d - w_exp_s;
        s1_eff_sub_d = w_sgn_a ^ w_sgn_b;
        s1_special_d = (w_exp_a == C_EXP_MAX) || (w_exp_b == C_EXP_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_l_q  <= 1'b0;
            s1_exp_l_q   <= '0;
            s1_man_l_q   <= '0;
            s1_man_s_q   <= '0;
            s1_shift_q   <= '0;
            s1_eff_sub_q <= 1'b0;
            s1_special_q <= 1'b0;
        end else if (!w_stall) begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_l_q  <= s1_sign_l_d;
            s1_exp_l_q   <= s1_exp_l_d;
            s1_man_l_q   <= s1_man_l_d;
            s1_man_s_q   <= s1_man_s_d;
            s1_shift_q   <= s1_shift_d;
            s1_eff_sub_q <= s1_eff_sub_d;
            s1_special_q <= s1_special_d;
        end
    end

    always_comb begin
        s2_valid_d   = s1_valid_q;
        s2_sign_l_d  = s1_sign_l_q;
        s2_exp_l_d   = s1_exp_l_q;
        s2_man_l_d   = s1_man_l_q;
        s2_eff_sub_d = s1_eff_sub_q;
        s2_special_d = s1_special_q;
        // Truncating alignment: bits shifted past the LSB are simply lost.
        if (32'(s1_shift_q) >= 32'(SIG_W)) begin
            s2_man_s_d = '0;
        end else begin
            s2_man_s_d = s1_man_s_q >> s1_shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_sign_l_q  <= 1'b0;
            s2_exp_l_q   <= '0;
            s2_man_l_q   <= '0;
            s2_man_s_q   <= '0;
            s2_eff_sub_q <= 1'b0;
            s2_special_q <= 1'b0;
        end else if (!w_stall) begin
            s2_valid_q   <= s2_valid_d;
            s2_sign_l_q  <= s2_sign_l_d;
            s2_exp_l_q   <= s2_exp_l_d;
            s2_man_l_q   <= s2_man_l_d;
            s2_man_s_q   <= s2_man_s_d;
            s2_eff_sub_q <= s2_eff_sub_d;
            s2_special_q <= s2_special_d;
        end
    end

    // The swap guarantees man_l >= man_s, so the subtract never borrows.
    assign w_sum   = s2_eff_sub_q ? ({1'b0, s2_man_l_q} - {1'b0, s2_man_s_q})
                                  : ({1'b0, s2_man_l_q} + {1'b0, s2_man_s_q});
    assign w_carry = w_sum[SIG_W];

    always_comb begin
        out_valid_d   = s2_valid_q;
        out_sign_d    = s2_sign_l_q;
        out_exp_d     = s2_exp_l_q;
        out_man_d     = w_sum[SIG_W-1:0];
        out_zero_d    = 1'b0;
        out_special_d = 1'b0;
        out_ovf_d     = 1'b0;
        if (s2_special_q) begin
            out_special_d = 1'b1;
            out_exp_d     = C_EXP_MAX;
            out_man_d     = C_SIG_NAN;
        end else if (w_sum == '0) begin
            out_zero_d = 1'b1;
            out_sign_d = 1'b0;
            out_man_d  = '0;
        end else if (w_carry) begin
            out_man_d = w_sum[SIG_W:1];
            out_exp_d = s2_exp_l_q + C_EXP_ONE;
            out_ovf_d = (s2_exp_l_q == (C_EXP_MAX - C_EXP_ONE));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_sign_q    <= 1'b0;
            out_exp_q     <= '0;
            out_man_q     <= '0;
            out_zero_q    <= 1'b0;
            out_special_q <= 1'b0;
            out_ovf_q     <= 1'b0;
        end else if (!w_stall) begin
            out_valid_q   <= out_valid_d;
            out_sign_q    <= out_sign_d;
            out_exp_q     <= out_exp_d;
            out_man_q     <= out_man_d;
            out_zero_q    <= out_zero_d;
            out_special_q <= out_special_d;
            out_ovf_q     <= out_ovf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sign    = out_sign_q;
    assign out_exp     = out_exp_q;
    assign out_man     = out_man_q;
    assign out_zero    = out_zero_q;
    assign out_special = out_special_q;
    assign out_ovf     = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_align_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_align_add
// Brief    : Directed vectors, backpressure/reset sequences and a randomized
//            stream scored against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_fp32_align_add;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] man;
        logic        zero;
        logic        special;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        res_t        want;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_man;
    logic        out_zero;
    logic        out_special;
    logic        out_ovf;

    res_t        got;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic        sb_en = 1'b0;
    res_t        exp_q[$];

    localparam int NV = 12;
    vec_t        vecs[NV];

    fp32_align_add dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_man     (out_man),
        .out_zero    (out_zero),
        .out_special (out_special),
        .out_ovf     (out_ovf)
    );

    always #5 clk = ~clk;

    assign got = {out_sign, out_exp, out_man, out_zero, out_special, out_ovf};

    // Reference: real-valued reasoning on integer significands.
    function automatic res_t model(input logic [31:0] ma_w, input logic [31:0] mb_w,
                                   input logic mop);
        res_t   r;
        int     ea, eb, el, dd;
        longint sa_m, sb_m, ml, ms, sum;
        logic   sa, sb, sl, ss;
        ea   = int'(ma_w[30:23]);
        eb   = int'(mb_w[30:23]);
        sa_m = (ea == 0) ? 0 : longint'(ma_w[22:0]) + (longint'(1) << 23);
        sb_m = (eb == 0) ? 0 : longint'(mb_w[22:0]) + (longint'(1) << 23);
        sa   = ma_w[31];
        sb   = mb_w[31] ^ mop;
        if (mb_w[30:0] > ma_w[30:0]) begin
            el = eb; ml = sb_m; sl = sb; ms = sa_m; ss = sa; dd = eb - ea;
        end else begin
            el = ea; ml = sa_m; sl = sa; ms = sb_m; ss = sb; dd = ea - eb;
        end
        ms  = (dd >= 24) ? 0 : (ms >> dd);
        sum = (sl != ss) ? ml - ms : ml + ms;
        r   = '0;
        if (ea == 255 || eb == 255) begin
            r.special = 1'b1; r.exp = 8'hFF; r.man = 24'h800000; r.sign = sl;
        end else if (sum == 0) begin
            r.zero = 1'b1; r.exp = 8'(el);
        end else if (sum >= (longint'(1) << 24)) begin
            r.sign = sl; r.man = 24'(sum / 2); r.exp = 8'(el + 1); r.ovf = (el == 254);
        end else begin
            r.sign = sl; r.man = 24'(sum); r.exp = 8'(el);
        end
        return r;
    endfunction

    function automatic vec_t mkv(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                                 input logic s, input logic [7:0] e, input logic [23:0] m,
                                 input logic z, input logic sp, input logic ov, input string nm);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.name = nm;
        v.want = {s, e, m, z, sp, ov};
        return v;
    endfunction

    task automatic check_res(input string nm, input res_t g, input res_t w);
        n_cmp++;
        if (g !== w) begin
            n_err++;
            $display("FAIL %s: got s=%0b e=%h m=%h z=%0b sp=%0b ov=%0b, want s=%0b e=%h m=%h z=%0b sp=%0b ov=%0b",
                     nm, g.sign, g.exp, g.man, g.zero, g.special, g.ovf,
                     w.sign, w.exp, w.man, w.zero, w.special, w.ovf);
        end
    endtask

    task automatic check_int(input string nm, input longint g, input longint w);
        n_cmp++;
        if (g != w) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, g, w);
        end
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic top);
        int   t;
        logic acc;
        a = ta; b = tb; op = top; in_valid = 1'b1;
        t = 0; acc = 1'b0;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want acceptance", t);
        end
    endtask

    task automatic rand_operands(output logic [31:0] ra, output logic [31:0] rb,
                                 output logic rop);
        int e;
        ra = $urandom; rb = $urandom; rop = 1'($urandom);
        case ($urandom_range(0, 7))
            0: ra[30:23] = 8'hFF;
            1: rb[30:23] = 8'h00;
            2, 3, 4: begin
                e = int'(ra[30:23]) + int'($urandom_range(0, 60)) - 30;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                rb[30:23] = 8'(e);
            end
            5: rb[30:0] = ra[30:0];
            6: begin ra[30:23] = 8'hFE; rb[30:23] = 8'hFE; end
            default: ;
        endcase
    endtask

    task automatic drain(input int expect_n, input string nm);
        int t;
        out_ready = 1'b1;
        t = 0;
        while (n_out < expect_n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_int({nm, "_count"}, n_out, expect_n);
        check_int({nm, "_leftover"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic done;
        logic [31:0] ra, rb;
        logic rop;
        int   saw;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;

        vecs[0]  = mkv(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 8'h80, 24'h800000, 1'b0, 1'b0, 1'b0, "one_plus_one");
        vecs[1]  = mkv(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 8'h7F, 24'h000000, 1'b1, 1'b0, 1'b0, "one_minus_one");
        vecs[2]  = mkv(32'h3FC00000, 32'h3F800000, 1'b1, 1'b0, 8'h7F, 24'h400000, 1'b0, 1'b0, 1'b0, "sub_unnorm");
        vecs[3]  = mkv(32'h3F800000, 32'h3FC00000, 1'b1, 1'b1, 8'h7F, 24'h400000, 1'b0, 1'b0, 1'b0, "sub_swap");
        vecs[4]  = mkv(32'h4B800000, 32'h3F800000, 1'b0, 1'b0, 8'h97, 24'h800000, 1'b0, 1'b0, 1'b0, "d24_drop");
        vecs[5]  = mkv(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 8'hFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, "overflow");
        vecs[6]  = mkv(32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 24'h800000, 1'b0, 1'b1, 1'b0, "special_a");
        vecs[7]  = mkv(32'h40000000, 32'h3F800000, 1'b0, 1'b0, 8'h80, 24'hC00000, 1'b0, 1'b0, 1'b0, "d1_add");
        vecs[8]  = mkv(32'hC0000000, 32'h3F800000, 1'b0, 1'b1, 8'h80, 24'h400000, 1'b0, 1'b0, 1'b0, "neg_eff_sub");
        vecs[9]  = mkv(32'h4B000000, 32'h3F800000, 1'b0, 1'b0, 8'h96, 24'h800001, 1'b0, 1'b0, 1'b0, "d23_keep");
        vecs[10] = mkv(32'h00000001, 32'h3F800000, 1'b0, 1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 1'b0, "denorm_flush");
        vecs[11] = mkv(32'h3F800000, 32'h7FC00000, 1'b1, 1'b1, 8'hFF, 24'h800000, 1'b0, 1'b1, 1'b0, "special_b_sub");

        // Scoreboard monitor: sampled on the falling edge, away from updates.
        fork
            begin
                res_t w;
                res_t prev_got;
                logic prev_stall;
                prev_stall = 1'b0;
                prev_got   = '0;
                forever begin
                    @(negedge clk);
                    if (sb_en && !rst) begin
                        if (out_valid && out_ready) begin
                            if (exp_q.size() == 0) begin
                                n_cmp++; n_err++;
                                $display("FAIL sb_unexpected: got a result, want none pending");
                            end else begin
                                w = exp_q.pop_front();
                                check_res("sb_result", got, w);
                                n_out++;
                            end
                        end
                        if (prev_stall) begin
                            check_int("hold_valid", out_valid, 1);
                            check_res("hold_data", got, prev_got);
                        end
                        check_int("in_ready_rule", in_ready, (out_valid && !out_ready) ? 0 : 1);
                        if (in_valid && in_ready)
                            exp_q.push_back(model(a, b, op));
                        prev_stall = out_valid && !out_ready;
                        prev_got   = got;
                    end else begin
                        prev_stall = 1'b0;
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_int("rst_out_valid", out_valid, 0);
        check_res("rst_outputs", got, '0);
        rst = 1'b0;
        #1;
        check_int("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check_int({vecs[i].name, "_latency"}, lat, 3);
            check_res(vecs[i].name, got, vecs[i].want);
        end
        repeat (3) @(posedge clk);
        #1;

        // Five back-to-back ops; downstream stalls 3 cycles after the first result.
        sb_en = 1'b1; n_out = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(vecs[i].a, vecs[i].b, vecs[i].op);
                in_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (!out_valid && t < 20) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                check_int("bp_in_ready_low", in_ready, 0);
                check_int("bp_valid_held", out_valid, 1);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain(5, "bp");

        // Randomized stream with random gaps and random backpressure.
        n_out = 0; done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    rand_operands(ra, rb, rop);
                    send(ra, rb, rop);
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain(300, "rand");

        // Reset with operations in flight.
        sb_en = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(vecs[i].a, vecs[i].b, vecs[i].op);
        in_valid = 1'b0;
        check_int("rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check_int("rst_async_valid", out_valid, 0);
        check_res("rst_async_outputs", got, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        saw = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) saw++;
        end
        check_int("rst_no_stale", saw, 0);

        a = vecs[7].a; b = vecs[7].b; op = vecs[7].op; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_int("post_rst_latency", lat, 3);
        check_res("post_rst_result", got, vecs[7].want);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
